uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Frame-aware N-channel UART TX combiner for the board UART pin; replaces the plain AND-merge of SoC and debug-bridge TX.
//  Tracks every serial input frame by frame and grants txd_o to one channel for a whole frame.
//  Frames that start while another channel owns the line are dropped and counted, never merged.
//  Sits between the UART sources (SoC UART, debug bridge, ...) and the uart_rxd_o pad flop.
// PARAMETERS
//  NUM_CH      2         number of serial TX inputs (1..8)
//  CLK_FREQ    60000000  clk_i frequency, Hz
//  BAUDRATE    1000000   line rate, Hz; CPB = CLK_FREQ/BAUDRATE (integer, >=4)
//  FRAME_BITS  10        start + data + stop bits per frame
// PORTS
//  clk_i         in   1              system clock
//  rst_i         in   1              synchronous reset, active high
//  txd_i         in   NUM_CH         serial TX lines from sources, idle high
//  txd_o         out  1              merged serial line to pad, registered
//  busy_o        out  1              a channel currently owns txd_o
//  owner_o       out  $clog2(NUM_CH) index of owning channel (valid when busy_o)
//  collision_o   out  1              one-cycle pulse per dropped frame
//  drop_count_o  out  16             dropped-frame count, saturating
// BEHAVIOUR
//  Reset: txd_o=1, busy_o=0, owner_o=0, collision_o=0, drop_count_o=0; all trackers idle; rr pointer=0.
//  Input stage: txd_i registered once (s_q) plus a previous copy (p_q); start edge = p_q[c] & ~s_q[c].
//  Per-channel tracker: IDLE -> ACTIVE on a start edge while IDLE; counter loads FRAME_BITS*CPB-1.
//   ACTIVE: counter decrements every cycle; at counter==0 -> IDLE (edges in that cycle are ignored).
//   False start: if s_q[c]==1 at elapsed count CPB/2 -> IDLE immediately (glitch rejected).
//   Start edges while ACTIVE are ignored (data-bit falling edges).
//  Arbiter FSM: FREE, OWNED.
//   FREE: if any start edge this cycle, grant one winner -> OWNED; owner_o=winner, busy_o=1 next cycle.
//   Simultaneous start edges: one winner; each loser counts as a dropped frame.
//   OWNED: txd_o <= s_q[owner]; start edges on non-owners count as drops.
//   OWNED -> FREE when owner tracker returns to IDLE (frame end or false start); txd_o <= 1 that cycle.
//   A non-owner frame still ACTIVE at release is never granted mid-frame; it becomes eligible at its next start edge.
//  FREE: txd_o <= 1.
//  Latency: txd_i to txd_o = 2 clk_i cycles, fixed; first start bit is not truncated.
//  Drops: collision_o=1 for exactly one cycle per drop event. If k drops occur in one cycle: pulse once, count += k.
//   drop_count_o saturates at 16'hFFFF.
//  NUM_CH==1: owner_o is 1 bit, tied 0; collisions impossible.
//  Reset mid-frame: everything returns to reset values next cycle; txd_o=1 (receiver sees a framing error, accepted).
// CONFIGURATION
//  UART_ARB_RR_EN defined: round-robin priority. Search starts at rr pointer; pointer <= winner+1 (mod NUM_CH) on each grant.
//  Not defined: fixed priority, lowest channel index wins; no rr pointer logic.
// TESTING (bench: CLK_FREQ=40, BAUDRATE=10 -> CPB=4, frame=40 cycles)
//  Single ch0 frame 0x55 -> txd_o replays the bit pattern 2 cycles late; busy_o for 40 cycles; owner_o=0; drop_count_o=0.
//  ch1 starts 8 cycles into a ch0 frame -> txd_o carries only ch0; collision_o pulses once; drop_count_o=1.
//   ch1's next frame, after both trackers are idle, is granted with owner_o=1.
//  ch0 and ch1 start in the same cycle, fixed priority -> owner_o=0, drop_count_o=1.
//   With UART_ARB_RR_EN, two such collisions in a row -> winners ch0 then ch1.
//  ch0 low pulse of 1 cycle -> false start: busy_o drops by elapsed count 2; txd_o never goes low for more than 1 cycle; no drop counted.
//  Force drop_count_o to 16'hFFFF, then cause another collision -> count stays 16'hFFFF; collision_o still pulses.
//  rst_i asserted 15 cycles into a frame -> next cycle txd_o=1, busy_o=0; a fresh ch1 start afterwards is granted normally.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Frame-aware UART TX combiner. Every serial input is tracked frame by
//   frame. The merged output line is granted to a single channel for a
//   whole frame. A frame that starts while another channel owns the line
//   is dropped and counted. It is never merged onto the output.
//
//   Optional feature macro: UART_ARB_RR_EN
//     defined     -> round-robin choice among simultaneous frame starts
//     not defined -> fixed priority, the lowest channel index wins
//
// Ports
//   clk_i         system clock
//   rst_i         synchronous reset, active high
//   txd_i         NUM_CH serial TX lines from the sources, idle high
//   txd_o         merged serial line to the pad, registered
//   busy_o        a channel currently owns txd_o
//   owner_o       index of the owning channel, valid while busy_o
//   collision_o   one-cycle pulse per cycle in which frames were dropped
//   drop_count_o  saturating count of dropped frames
module uart_tx_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int CLK_FREQ   = 60000000,
  parameter int BAUDRATE   = 1000000,
  parameter int FRAME_BITS = 10,
  localparam int OW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] txd_i,
  output logic              txd_o,
  output logic              busy_o,
  output logic [OW-1:0]     owner_o,
  output logic              collision_o,
  output logic [15:0]       drop_count_o
);

  localparam int CPB       = CLK_FREQ / BAUDRATE;
  localparam int FRAME_CYC = FRAME_BITS * CPB;
  localparam int CW        = $clog2(FRAME_CYC);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(FRAME_CYC - 1);
  // Counter value at which half a bit time has elapsed in the start bit.
  localparam logic [CW-1:0] CNT_CHECK = CW'(FRAME_CYC - 1 - CPB / 2);

  typedef enum logic {TRK_IDLE, TRK_ACTIVE} trk_state_e;
  typedef enum logic {ARB_FREE, ARB_OWNED} arb_state_e;

  logic [NUM_CH-1:0] s_q, s_d, p_q, p_d;
  trk_state_e        trk_q [NUM_CH];
  trk_state_e        trk_d [NUM_CH];
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];
  logic [NUM_CH-1:0] frame_start;
  logic [NUM_CH-1:0] trk_busy_next;

  arb_state_e  state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
  logic        coll_q, coll_d;
  logic [15:0] drop_count_q, drop_count_d;

  logic [OW-1:0]     winner;
  logic [3:0]        start_cnt;
  logic [3:0]        drop_k;
  logic [NUM_CH-1:0] owner_mask;
  logic [16:0]       drop_sum;

`ifdef UART_ARB_RR_EN
  logic [OW-1:0] rr_q, rr_d;
  logic          win_found;
  int            rr_idx;
`endif

  // Input stage: one synchronising register plus a delayed copy. A start
  // edge only counts as a frame start when that channel's tracker is idle.
  // This keeps falling edges on data bits from looking like new frames.
  always_comb begin
    s_d = txd_i;
    p_d = s_q;
    for (int c = 0; c < NUM_CH; c++) begin
      frame_start[c] = p_q[c] & ~s_q[c] & (trk_q[c] == TRK_IDLE);
    end
  end

  // Per-channel frame trackers. Each tracker follows its channel for one
  // frame length. It gives up early if the line is high again half a bit
  // into the start bit, which rejects a glitch.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      trk_d[c] = trk_q[c];
      cnt_d[c] = cnt_q[c];
      case (trk_q[c])
        TRK_IDLE: begin
          if (frame_start[c]) begin
            trk_d[c] = TRK_ACTIVE;
            cnt_d[c] = CNT_LOAD;
          end
        end
        default: begin
          if (cnt_q[c] == '0) begin
            trk_d[c] = TRK_IDLE;
          end else if (cnt_q[c] == CNT_CHECK && s_q[c]) begin
            trk_d[c] = TRK_IDLE;
            cnt_d[c] = '0;
          end else begin
            cnt_d[c] = cnt_q[c] - 1'b1;
          end
        end
      endcase
      trk_busy_next[c] = (trk_d[c] == TRK_ACTIVE);
    end
  end

  // Winner selection among the channels that start a frame this cycle,
  // together with the number of simultaneous starts.
`ifdef UART_ARB_RR_EN
  always_comb begin
    winner    = '0;
    win_found = 1'b0;
    rr_idx    = 0;
    for (int j = 0; j < NUM_CH; j++) begin
      rr_idx = (int'(rr_q) + j) % NUM_CH;
      if (!win_found && frame_start[rr_idx]) begin
        win_found = 1'b1;
        winner    = OW'(rr_idx);
      end
    end
    rr_d = rr_q;
    if (state_q == ARB_FREE && (|frame_start)) begin
      rr_d = (winner == OW'(NUM_CH - 1)) ? '0 : winner + 1'b1;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (frame_start[i]) begin
        winner = OW'(i);
      end
    end
  end
`endif

  always_comb begin
    start_cnt  = '0;
    owner_mask = '0;
    owner_mask[owner_q] = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      start_cnt = start_cnt + {3'b000, frame_start[c]};
    end
  end

  // Arbiter. In the grant cycle the winner's start bit is passed straight
  // through, so the output delay stays at two cycles from the very first
  // bit. The owner is released in the cycle its tracker finishes. The line
  // is then forced idle, so a stale bit is never replayed after release.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    txd_d   = 1'b1;
    drop_k  = '0;
    case (state_q)
      ARB_FREE: begin
        if (|frame_start) begin
          state_d = ARB_OWNED;
          owner_d = winner;
          txd_d   = s_q[winner];
          drop_k  = start_cnt - 4'd1;
        end
      end
      default: begin
        for (int c = 0; c < NUM_CH; c++) begin
          drop_k = drop_k + {3'b000, frame_start[c] & ~owner_mask[c]};
        end
        if (!trk_busy_next[owner_q]) begin
          state_d = ARB_FREE;
          txd_d   = 1'b1;
        end else begin
          txd_d   = s_q[owner_q];
        end
      end
    endcase
    busy_d       = (state_d == ARB_OWNED);
    coll_d       = (drop_k != 4'd0);
    drop_sum     = {1'b0, drop_count_q} + {13'd0, drop_k};
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // All state registers. Reset brings everything back to idle. A frame in
  // flight is simply cut off.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q          <= '1;
      p_q          <= '1;
      for (int c = 0; c < NUM_CH; c++) begin
        trk_q[c] <= TRK_IDLE;
        cnt_q[c] <= '0;
      end
      state_q      <= ARB_FREE;
      owner_q      <= '0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
      coll_q       <= 1'b0;
      drop_count_q <= '0;
`ifdef UART_ARB_RR_EN
      rr_q         <= '0;
`endif
    end else begin
      s_q          <= s_d;
      p_q          <= p_d;
      for (int c = 0; c < NUM_CH; c++) begin
        trk_q[c] <= trk_d[c];
        cnt_q[c] <= cnt_d[c];
      end
      state_q      <= state_d;
      owner_q      <= owner_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
      coll_q       <= coll_d;
      drop_count_q <= drop_count_d;
`ifdef UART_ARB_RR_EN
      rr_q         <= rr_d;
`endif
    end
  end

  assign txd_o        = txd_q;
  assign busy_o       = busy_q;
  assign owner_o      = owner_q;
  assign collision_o  = coll_q;
  assign drop_count_o = drop_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter with two channels and 4 clocks
//   per bit, which gives 40-cycle frames. Frame scenarios come from a table.
//   Each table row lists the frames driven and the channel whose frame must
//   appear on txd_o. Expected line values are queued as they are driven and
//   compared two cycles later. The false start, the saturation case and the
//   reset mid-frame are written out by hand.
module tb_uart_tx_arbiter;

  localparam int NUM_CH = 2;
  localparam int FRAME  = 40;

`ifdef UART_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [1:0]  txd_i = 2'b11;
  logic        txd_o;
  logic        busy_o;
  logic [0:0]  owner_o;
  logic        collision_o;
  logic [15:0] drop_count_o;

  uart_tx_arbiter #(
    .NUM_CH     (NUM_CH),
    .CLK_FREQ   (40),
    .BAUDRATE   (10),
    .FRAME_BITS (10)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .txd_i        (txd_i),
    .txd_o        (txd_o),
    .busy_o       (busy_o),
    .owner_o      (owner_o),
    .collision_o  (collision_o),
    .drop_count_o (drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int   due;
    logic txd;
    logic busy;
    logic own;
  } sb_entry_t;

  typedef struct {
    bit         rst;
    bit         sat;
    int         s0;
    logic [7:0] d0;
    int         s1;
    logic [7:0] d1;
    int         own_fix;
    int         own_rr;
    int         drops;
  } vec_t;

  sb_entry_t   sb[$];
  vec_t        vecs[7];
  vec_t        after_reset_vec;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          coll_seen = 0;
  logic [15:0] exp_drops = '0;

  // Serial level of a frame that starts at step s (start bit low), at step k.
  function automatic logic bitAt(input int s, input logic [7:0] d, input int k);
    int idx;
    if (s < 0 || k < s || k >= s + FRAME) return 1'b1;
    idx = (k - s) / 4;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return d[idx-1];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
               name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus. Queued expectations that fall due are compared
  // first. Then the new input is driven, and if asked, the line value it
  // must produce two cycles later is queued.
  task automatic applyStimulus(input logic [1:0] v, input bit push,
                               input logic et, input logic eb, input logic eo);
    sb_entry_t e;
    @(negedge clk_i);
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checkOutput("txd_o", {31'd0, txd_o}, {31'd0, e.txd});
      checkOutput("busy_o", {31'd0, busy_o}, {31'd0, e.busy});
      if (e.busy) checkOutput("owner_o", {31'd0, owner_o}, {31'd0, e.own});
    end
    if (collision_o) coll_seen++;
    txd_i = v;
    if (push) sb.push_back('{due: cyc + 2, txd: et, busy: eb, own: eo});
  endtask

  task automatic applyReset();
    @(negedge clk_i);
    cyc++;
    rst_i = 1'b1;
    txd_i = 2'b11;
    @(negedge clk_i);
    cyc++;
    checkOutput("reset txd_o", {31'd0, txd_o}, 32'd1);
    checkOutput("reset busy_o", {31'd0, busy_o}, 32'd0);
    checkOutput("reset owner_o", {31'd0, owner_o}, 32'd0);
    checkOutput("reset collision_o", {31'd0, collision_o}, 32'd0);
    checkOutput("reset drop_count_o", {16'd0, drop_count_o}, 32'd0);
    rst_i = 1'b0;
    sb.delete();
    exp_drops = '0;
  endtask

  task automatic runVector(input vec_t v);
    int         own_exp;
    int         s_own;
    bit         inwin;
    logic [1:0] bits;
    logic [16:0] sum;
    if (v.rst) applyReset();
    if (v.sat) begin
      @(negedge clk_i);
      force dut.drop_count_q = 16'hFFFF;
      @(negedge clk_i);
      release dut.drop_count_q;
      @(negedge clk_i);
      cyc += 3;
      checkOutput("drop_count forced", {16'd0, drop_count_o}, 32'h0000FFFF);
      exp_drops = 16'hFFFF;
    end
    coll_seen = 0;
    own_exp = RR_MODE ? v.own_rr : v.own_fix;
    s_own = (own_exp == 0) ? v.s0 : v.s1;
    for (int k = 0; k < 60; k++) begin
      bits  = {bitAt(v.s1, v.d1, k), bitAt(v.s0, v.d0, k)};
      inwin = (own_exp >= 0) && (k >= s_own) && (k < s_own + FRAME);
      applyStimulus(bits, 1'b1, inwin ? bits[own_exp] : 1'b1, inwin,
                    (own_exp == 1));
    end
    applyStimulus(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    sum = {1'b0, exp_drops} + 17'(v.drops);
    exp_drops = sum[16] ? 16'hFFFF : sum[15:0];
    checkOutput("drop_count_o", {16'd0, drop_count_o}, {16'd0, exp_drops});
    checkOutput("collision pulses", coll_seen, v.drops);
  endtask

  initial begin
    vecs[0] = '{rst: 1, sat: 0, s0: 2,  d0: 8'h55, s1: -1, d1: 8'h00,
                own_fix: 0, own_rr: 0, drops: 0};
    vecs[1] = '{rst: 1, sat: 0, s0: 2,  d0: 8'hA3, s1: 10, d1: 8'h3C,
                own_fix: 0, own_rr: 0, drops: 1};
    vecs[2] = '{rst: 0, sat: 0, s0: -1, d0: 8'h00, s1: 2,  d1: 8'h96,
                own_fix: 1, own_rr: 1, drops: 0};
    vecs[3] = '{rst: 1, sat: 0, s0: 2,  d0: 8'h0F, s1: 2,  d1: 8'hF0,
                own_fix: 0, own_rr: 0, drops: 1};
    vecs[4] = '{rst: 0, sat: 0, s0: 2,  d0: 8'h81, s1: 2,  d1: 8'h7E,
                own_fix: 0, own_rr: 1, drops: 1};
    vecs[5] = '{rst: 1, sat: 1, s0: 2,  d0: 8'h12, s1: 2,  d1: 8'h34,
                own_fix: 0, own_rr: 0, drops: 1};
    vecs[6] = '{rst: 1, sat: 0, s0: 10, d0: 8'hC5, s1: 2,  d1: 8'h5A,
                own_fix: 1, own_rr: 1, drops: 1};
    after_reset_vec = '{rst: 0, sat: 0, s0: -1, d0: 8'h00, s1: 2, d1: 8'hE7,
                        own_fix: 1, own_rr: 1, drops: 0};

    $display("[TB] start, round-robin=%0d", RR_MODE);
    for (int i = 0; i < 7; i++) begin
      runVector(vecs[i]);
    end

    // A one-cycle low glitch on ch0 is granted and then released at half a
    // bit time. Nothing is dropped.
    applyReset();
    coll_seen = 0;
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("false start drop_count_o", {16'd0, drop_count_o}, 32'd0);
    checkOutput("false start collisions", coll_seen, 0);

    // Reset 15 cycles into a ch0 frame, then a fresh ch1 frame.
    applyReset();
    for (int k = 0; k < 16; k++) begin
      applyStimulus({1'b1, bitAt(1, 8'h55, k)}, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk_i);
    cyc++;
    checkOutput("mid-frame busy_o", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    txd_i = 2'b11;
    @(negedge clk_i);
    cyc++;
    checkOutput("post-reset txd_o", {31'd0, txd_o}, 32'd1);
    checkOutput("post-reset busy_o", {31'd0, busy_o}, 32'd0);
    checkOutput("post-reset drop_count_o", {16'd0, drop_count_o}, 32'd0);
    rst_i = 1'b0;
    sb.delete();
    exp_drops = '0;
    runVector(after_reset_vec);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
